// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle; sign fix-up in a final FIX cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            startE,
  input  logic [1:0]      opE,
  input  logic [XLEN-1:0] srcAE,
  input  logic [XLEN-1:0] srcBE,
  input  logic            flushE,
  input  logic            mthiE,
  input  logic            mtloE,
  input  logic [XLEN-1:0] mtDataE,
  output logic            stallE,
  output logic            doneM,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] LAST = CW'(XLEN);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   aMag, bMag;
  logic [2*XLEN-1:0] acc;
  logic              aNeg, bNeg, isDiv, divZero;

  logic              accept, srcANeg, srcBNeg;
  logic [XLEN-1:0]   srcAMag, srcBMag;
  logic [XLEN:0]     mulSum, trial, diff;
  logic [2*XLEN-1:0] mulStep, divStep, prodFix;
  logic [XLEN-1:0]   quoFix, remFix;

  always_comb begin
    accept  = startE & ~flushE & ((state == IDLE) | (state == DONE));
    stallE  = accept | (state == MUL) | (state == DIV) | (state == FIX);
    srcANeg = ~opE[0] & srcAE[XLEN-1];
    srcBNeg = ~opE[0] & srcBE[XLEN-1];
    srcAMag = srcANeg ? -srcAE : srcAE;
    srcBMag = srcBNeg ? -srcBE : srcBE;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mulSum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, aMag} : '0);
    mulStep = {mulSum, acc[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = trial - {1'b0, bMag};
    divStep = diff[XLEN] ? {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                         : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    // Remainder takes the dividend's sign, which also restores srcAE exactly on divide by zero.
    prodFix = (aNeg ^ bNeg) ? -acc : acc;
    quoFix  = ((aNeg ^ bNeg) & ~divZero) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remFix  = aNeg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      aMag    <= '0;
      bMag    <= '0;
      acc     <= '0;
      aNeg    <= 1'b0;
      bNeg    <= 1'b0;
      isDiv   <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      doneM   <= 1'b0;
    end else begin
      doneM <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            aMag    <= srcAMag;
            bMag    <= srcBMag;
            aNeg    <= srcANeg;
            bNeg    <= srcBNeg;
            isDiv   <= opE[1];
            divZero <= (srcBE == '0);
            acc     <= {{XLEN{1'b0}}, opE[1] ? srcAMag : srcBMag};
            cnt     <= '0;
            state   <= opE[1] ? DIV : MUL;
          end else begin
            state <= IDLE;
            if (mthiE) hi <= mtDataE;
            if (mtloE) lo <= mtDataE;
          end
        end
        MUL, DIV: begin
          if (flushE) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state <= FIX;
          end else begin
            acc <= (state == DIV) ? divStep : mulStep;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (flushE) begin
            state <= IDLE;
          end else begin
            if (isDiv) begin
              hi <= remFix;
              lo <= quoFix;
            end else begin
              hi <= prodFix[2*XLEN-1:XLEN];
              lo <= prodFix[XLEN-1:0];
            end
            doneM <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32): vector table plus
// hand-written flush, back-to-back, reset and move-to sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        startE, flushE, mthiE, mtloE;
  logic [1:0]  opE;
  logic [31:0] srcAE, srcBE, mtDataE;
  logic        stallE, doneM;
  logic [31:0] hi, lo;

  int unsigned passCnt = 0;
  int unsigned totalCnt = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .startE(startE), .opE(opE),
    .srcAE(srcAE), .srcBE(srcBE), .flushE(flushE),
    .mthiE(mthiE), .mtloE(mtloE), .mtDataE(mtDataE),
    .stallE(stallE), .doneM(doneM), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b, expHi, expLo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the cycle following doneM.
  task automatic runOp(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    logic stallOk;
    startE = 1'b1; opE = op; srcAE = a; srcBE = b;
    #1 chk({nm, " stall@start"}, 64'(stallE), 64'd1);
    @(posedge clk); @(negedge clk);
    startE = 1'b0; srcAE = $urandom; srcBE = $urandom;
    cyc = 0; stallOk = 1'b1;
    while (!doneM && cyc < 100) begin
      if (!stallE) stallOk = 1'b0;
      @(negedge clk); cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'd34);
    chk({nm, " stallBusy"}, 64'(stallOk), 64'd1);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " stallDone"}, 64'(stallE), 64'd0);
    @(negedge clk);
    chk({nm, " donePulse"}, 64'(doneM), 64'd0);
  endtask

  vec_t vecs[13];

  initial begin
    int e;
    logic seen;

    vecs[0]  = '{"mult7xm3",   2'b00, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{"multuMax",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"multMinSq",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{"multuShift", 2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[4]  = '{"multM1x1",   2'b00, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5]  = '{"divu100/7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{"divM7/2",    2'b10, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{"div5/0",     2'b10, 32'h5,        32'h0,        32'h5,        32'hFFFFFFFF};
    vecs[8]  = '{"divOvf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[9]  = '{"divM5/0",    2'b10, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[10] = '{"divuMax/16", 2'b11, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF};
    vecs[11] = '{"div7/m2",    2'b10, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{"divuMin/m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};

    rst_n = 1'b0; startE = 1'b0; flushE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
    opE = 2'b00; srcAE = '0; srcBE = '0; mtDataE = '0;
    repeat (3) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset stall", 64'(stallE), 64'd0);
    chk("reset done", 64'(doneM), 64'd0);

    // First start issued in the same cycle reset is released.
    rst_n = 1'b1;
    foreach (vecs[i]) runOp(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo);

    // Flush mid-MULTU; move-to writes while busy or with a start are ignored.
    mthiE = 1'b1; mtDataE = 32'hAAAA; @(negedge clk); mthiE = 1'b0;
    mtloE = 1'b1; mtDataE = 32'h5555; @(negedge clk);
    chk("mthi", 64'(hi), 64'hAAAA);
    chk("mtlo", 64'(lo), 64'h5555);
    mtDataE = 32'hDEAD; startE = 1'b1; opE = 2'b01; srcAE = 32'd3; srcBE = 32'd5;
    @(posedge clk); @(negedge clk);
    e = 0; startE = 1'b0; mtloE = 1'b0;
    chk("mtlo with start", 64'(lo), 64'h5555);
    while (e < 9) begin
      mtloE = (e == 4);
      @(negedge clk); e++;
    end
    mtloE = 1'b0;
    chk("mtlo busy", 64'(lo), 64'h5555);
    flushE = 1'b1; @(negedge clk); flushE = 1'b0;
    chk("flush stall", 64'(stallE), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (doneM) seen = 1'b1; end
    chk("flush noDone", 64'(seen), 64'd0);
    chk("flush hi", 64'(hi), 64'hAAAA);
    chk("flush lo", 64'(lo), 64'h5555);

    // Start together with flush is not accepted.
    startE = 1'b1; flushE = 1'b1; opE = 2'b00; srcAE = 32'd9; srcBE = 32'd9;
    #1 chk("flushStart stallComb", 64'(stallE), 64'd0);
    @(posedge clk); @(negedge clk);
    startE = 1'b0; flushE = 1'b0;
    chk("flushStart stall", 64'(stallE), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (doneM) seen = 1'b1; end
    chk("flushStart noDone", 64'(seen), 64'd0);
    chk("flushStart lo", 64'(lo), 64'h5555);

    // Back-to-back: second start held through the DONE cycle.
    startE = 1'b1; opE = 2'b01; srcAE = 32'd3; srcBE = 32'd5;
    @(posedge clk); @(negedge clk);
    opE = 2'b11; srcAE = 32'd100; srcBE = 32'd7;
    e = 0; seen = 1'b1;
    while (!doneM && e < 100) begin
      if (!stallE) seen = 1'b0;
      @(negedge clk); e++;
    end
    chk("b2b first edge", 64'(e), 64'd34);
    chk("b2b first hi", 64'(hi), 64'd0);
    chk("b2b first lo", 64'(lo), 64'd15);
    chk("b2b stallInDone", 64'(stallE), 64'd1);
    @(negedge clk); e++;
    startE = 1'b0;
    while (!doneM && e < 200) begin
      if (!stallE) seen = 1'b0;
      @(negedge clk); e++;
    end
    chk("b2b stallHeld", 64'(seen), 64'd1);
    chk("b2b second edge", 64'(e), 64'd69);
    chk("b2b second hi", 64'(hi), 64'd2);
    chk("b2b second lo", 64'(lo), 64'd14);

    // Asynchronous reset in the middle of a DIV, then move-to-LO.
    @(negedge clk);
    startE = 1'b1; opE = 2'b10; srcAE = 32'd1000; srcBE = 32'd3;
    @(posedge clk); @(negedge clk);
    startE = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midReset hi", 64'(hi), 64'd0);
    chk("midReset lo", 64'(lo), 64'd0);
    chk("midReset stall", 64'(stallE), 64'd0);
    chk("midReset done", 64'(doneM), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; mtloE = 1'b1; mtDataE = 32'h1234;
    @(negedge clk);
    mtloE = 1'b0;
    chk("postReset mtlo", 64'(lo), 64'h1234);
    chk("postReset hi", 64'(hi), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (doneM) seen = 1'b1; end
    chk("postReset noDone", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand, HI and LO width.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port startE, input, 1: EX-stage mult/div issue request.
REQ-005 The block SHALL have port opE, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have port srcAE, input, XLEN: forwarded rs value (multiplicand/dividend).
REQ-007 The block SHALL have port srcBE, input, XLEN: forwarded rt value (multiplier/divisor).
REQ-008 The block SHALL have port flushE, input, 1: squash EX instruction; abort any operation in progress.
REQ-009 The block SHALL have ports mthiE and mtloE, input, 1 each, and mtDataE, input, XLEN: direct HI/LO write.
REQ-010 The block SHALL have port stallE, output, 1: hold IF/ID/EX while high.
REQ-011 The block SHALL have port doneM, output, 1: one-cycle result-written pulse.
REQ-012 The block SHALL have ports hi and lo, output, XLEN each: architectural HI/LO registers.

Function
REQ-013 The FSM SHALL have states IDLE, MUL, DIV, FIX and DONE; DONE SHALL accept startE exactly as IDLE does.
REQ-014 In IDLE or DONE with startE=1 and flushE=0, the block SHALL latch operand magnitudes and signs, clear the iteration counter, and enter MUL (op 0x) or DIV (op 1x).
REQ-015 MUL SHALL perform one shift-add step per cycle and DIV one restoring shift-subtract step per cycle, each for exactly XLEN cycles, then enter FIX.
REQ-016 FIX SHALL, for signed ops only, negate the product if the operand signs differ, negate the quotient if the signs differ, and give the remainder the dividend's sign; it SHALL then enter DONE.
REQ-017 On the FIX->DONE edge, hi/lo SHALL load {product[2*XLEN-1:XLEN], product[XLEN-1:0]} or {remainder, quotient}; doneM SHALL be 1 for the DONE cycle only.
REQ-018 Latency: with start sampled at edge 0, hi/lo SHALL be updated at edge XLEN+2 (edge 34 for XLEN=32).
REQ-019 stallE SHALL equal (startE & ~flushE & state in {IDLE,DONE}) | state in {MUL,DIV,FIX}; it SHALL be 0 in DONE when startE=0.
REQ-020 Without a new start, DONE SHALL return to IDLE after one cycle.
REQ-021 Divide by zero SHALL take normal latency and yield lo = all ones, hi = srcAE as issued, with no FIX sign correction.
REQ-022 Signed overflow (most-negative / -1) SHALL yield lo = most-negative value and hi = 0.
REQ-023 flushE=1 in MUL, DIV or FIX SHALL return the FSM to IDLE at the next edge with hi/lo unchanged and no doneM pulse; flushE=1 together with startE SHALL prevent the start.
REQ-024 mthiE/mtloE SHALL write mtDataE to hi/lo at the next edge only in IDLE or DONE; they SHALL be ignored in other states and when a start is accepted in the same cycle.
REQ-025 Operands SHALL be sampled only at start acceptance; changes on srcAE/srcBE while busy SHALL have no effect.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, hi=0, lo=0, counter=0, doneM=0 and stallE=0 (startE low), including mid-operation.
REQ-027 After rst_n deasserts, the first start SHALL be accepted at the first rising edge with rst_n=1.

Verification
REQ-028 MULT srcA=7, srcB=0xFFFFFFFD -> stallE high for edges 0..33, hi=0xFFFFFFFF, lo=0xFFFFFFEB at edge 34, doneM one cycle.
REQ-029 DIVU 100/7 -> lo=14, hi=2; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-030 DIV 5/0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 Start MULTU, assert flushE at edge 10 -> stallE low from edge 11, hi/lo unchanged, no doneM.
REQ-032 Back-to-back: startE held in the DONE cycle -> second op accepted, stallE stays high, second doneM at edge 69.
REQ-033 Assert rst_n=0 at edge 20 of a DIV -> hi=lo=0 and stallE=0 immediately; mtloE with 0x1234 in IDLE -> lo=0x1234 next edge.
